mdu_issue_ctrl: RTL and testbench

//  Sequences the multi-cycle multiply/divide unit (MDU) for the 5-stage pipeline. Decodes the E-stage MDU op.

---
 rtl/mdu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// MDU issue sequencer: start pulse, latency countdown, D-stage stall.
// Optional MDU_PERF_CNT_EN builds the stall-cycle counter.
module mdu_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MDUValid,
  input  logic [3:0]  E_MDUOP,
  input  logic        E_Flush,
  input  logic        D_MDUUse,
  output logic        Start,
  output logic [3:0]  MDUOP,
  output logic [3:0]  Time,
  output logic [1:0]  ReadHILO,
  output logic        Stall,
  output logic        ProtoErr,
  output logic [31:0] PerfStallCnt
);

  localparam logic [3:0] MulT = 4'(MULT_CYCLES);
  localparam logic [3:0] DivT = 4'(DIV_CYCLES);

  localparam logic [3:0] OpMult  = 4'b0001;
  localparam logic [3:0] OpMultu = 4'b0010;
  localparam logic [3:0] OpDiv   = 4'b0011;
  localparam logic [3:0] OpDivu  = 4'b0100;
  localparam logic [3:0] OpMfhi  = 4'b0111;
  localparam logic [3:0] OpMflo  = 4'b1001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       perr_q, perr_d;

  logic       fire;
  logic       is_mul;
  logic       is_div;
  logic       idle;
  logic       start;
  logic [3:0] lat;

  // Op decode and issue qualification
  always_comb begin
    fire   = E_MDUValid & ~E_Flush;
    is_mul = (E_MDUOP == OpMult) | (E_MDUOP == OpMultu);
    is_div = (E_MDUOP == OpDiv) | (E_MDUOP == OpDivu);
    idle   = (state_q == IDLE);
    start  = fire & (is_mul | is_div) & idle;
    lat    = 4'd0;
    unique case (1'b1)
      is_mul:  lat = MulT;
      is_div:  lat = DivT;
      default: lat = 4'd0;
    endcase
  end

  // State, countdown and sticky error registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  // Next state: busy for exactly lat cycles counting the start cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q | (fire & ~idle);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (lat <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = RUN;
            cnt_d   = lat - 4'd1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs: ops only reach the MDU while it is idle
  always_comb begin
    Start    = start;
    Time     = start ? lat : 4'd0;
    MDUOP    = (fire & idle) ? E_MDUOP : 4'd0;
    ReadHILO = 2'b00;
    if (fire & idle) begin
      if (E_MDUOP == OpMfhi) ReadHILO = 2'b10;
      if (E_MDUOP == OpMflo) ReadHILO = 2'b01;
    end
    Stall    = D_MDUUse & (start | ~idle);
    ProtoErr = perr_q;
  end

`ifdef MDU_PERF_CNT_EN
  logic [31:0] perf_q;

  // Count every stalled cycle outside reset
  always_ff @(posedge clk) begin
    if (!reset) perf_q <= 32'd0;
    else if (Stall) perf_q <= perf_q + 32'd1;
  end

  assign PerfStallCnt = perf_q;
`else
  assign PerfStallCnt = 32'd0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl.
// Inputs change at negedge; outputs sampled 1ns later.
module tb_mdu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_MDUValid;
  logic [3:0]  E_MDUOP;
  logic        E_Flush;
  logic        D_MDUUse;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [3:0]  Time;
  logic [1:0]  ReadHILO;
  logic        Stall;
  logic        ProtoErr;
  logic [31:0] PerfStallCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .E_MDUValid  (E_MDUValid),
    .E_MDUOP     (E_MDUOP),
    .E_Flush     (E_Flush),
    .D_MDUUse    (D_MDUUse),
    .Start       (Start),
    .MDUOP       (MDUOP),
    .Time        (Time),
    .ReadHILO    (ReadHILO),
    .Stall       (Stall),
    .ProtoErr    (ProtoErr),
    .PerfStallCnt(PerfStallCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input logic [3:0] op,
                     input logic fl, input logic du);
    @(negedge clk);
    reset      = rst;
    E_MDUValid = v;
    E_MDUOP    = op;
    E_Flush    = fl;
    D_MDUUse   = du;
    #1;
  endtask

  logic [31:0] perf_exp;

  initial begin
`ifdef MDU_PERF_CNT_EN
    perf_exp = 32'd10;
`else
    perf_exp = 32'd0;
`endif
    reset = 1'b0; E_MDUValid = 1'b0; E_MDUOP = 4'd0;
    E_Flush = 1'b0; D_MDUUse = 1'b0;

    // reset held low 2 cycles with a valid mult in E
    cyc(0, 1, 4'b0001, 0, 1);
    cyc(0, 1, 4'b0001, 0, 1);
    cyc(1, 0, 4'b0000, 0, 0);
    chk("rst_start", 32'(Start), 0);
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_perr", 32'(ProtoErr), 0);
    chk("rst_mduop", 32'(MDUOP), 0);
    chk("rst_hilo", 32'(ReadHILO), 0);
    chk("rst_time", 32'(Time), 0);
    chk("rst_perf", PerfStallCnt, 0);

    // mult: stall 5 cycles, free on 6th
    cyc(1, 1, 4'b0001, 0, 1);
    chk("mul_start", 32'(Start), 1);
    chk("mul_time", 32'(Time), 5);
    chk("mul_op", 32'(MDUOP), 1);
    chk("mul_stall1", 32'(Stall), 1);
    for (int i = 2; i <= 5; i++) begin
      cyc(1, 0, 4'b0000, 0, 1);
      chk($sformatf("mul_stall%0d", i), 32'(Stall), 1);
      chk($sformatf("mul_nostart%0d", i), 32'(Start), 0);
    end
    cyc(1, 0, 4'b0000, 0, 1);
    chk("mul_stall6", 32'(Stall), 0);

    // divu flushed on its issue cycle
    cyc(1, 1, 4'b0100, 1, 1);
    chk("flu_start", 32'(Start), 0);
    chk("flu_op", 32'(MDUOP), 0);
    chk("flu_stall", 32'(Stall), 0);
    cyc(1, 0, 4'b0000, 0, 1);
    chk("flu_idle", 32'(Stall), 0);

    // move/read ops pass through while idle
    cyc(1, 1, 4'b0101, 0, 1);
    chk("mthi_op", 32'(MDUOP), 5);
    chk("mthi_start", 32'(Start), 0);
    chk("mthi_stall", 32'(Stall), 0);
    cyc(1, 1, 4'b0111, 0, 0);
    chk("mfhi_hilo", 32'(ReadHILO), 2);
    cyc(1, 1, 4'b1001, 0, 0);
    chk("mflo_hilo", 32'(ReadHILO), 1);
    chk("mflo_op", 32'(MDUOP), 9);
    cyc(1, 1, 4'b1000, 0, 0);
    chk("swap_op", 32'(MDUOP), 8);
    chk("swap_time", 32'(Time), 0);
    cyc(1, 0, 4'b0000, 0, 1);
    chk("mv_idle", 32'(Stall), 0);

    // div then mflo in E on cycle 3 -> protocol error
    cyc(1, 1, 4'b0011, 0, 1);
    chk("div_start", 32'(Start), 1);
    chk("div_time", 32'(Time), 10);
    cyc(1, 0, 4'b0000, 0, 1);
    cyc(1, 1, 4'b1001, 0, 1);
    chk("viol_hilo", 32'(ReadHILO), 0);
    chk("viol_op", 32'(MDUOP), 0);
    chk("viol_start", 32'(Start), 0);
    chk("viol_stall", 32'(Stall), 1);
    for (int i = 4; i <= 10; i++) begin
      cyc(1, 0, 4'b0000, 0, 1);
      chk($sformatf("viol_perr%0d", i), 32'(ProtoErr), 1);
      chk($sformatf("viol_stall%0d", i), 32'(Stall), 1);
    end
    cyc(1, 0, 4'b0000, 0, 1);
    chk("viol_done", 32'(Stall), 0);
    chk("viol_sticky", 32'(ProtoErr), 1);
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(1, 0, 4'b0000, 0, 0);
    chk("perr_clr", 32'(ProtoErr), 0);

    // mult, flush while running, div accepted back-to-back
    cyc(1, 1, 4'b0001, 0, 1);
    chk("b2b_start1", 32'(Start), 1);
    cyc(1, 1, 4'b0011, 1, 1);
    chk("runflu_start", 32'(Start), 0);
    chk("runflu_stall", 32'(Stall), 1);
    for (int i = 3; i <= 5; i++) begin
      cyc(1, 0, 4'b0000, 0, 1);
      chk($sformatf("b2b_stall%0d", i), 32'(Stall), 1);
    end
    chk("runflu_perr", 32'(ProtoErr), 0);
    cyc(1, 1, 4'b0011, 0, 1);
    chk("b2b_start2", 32'(Start), 1);
    chk("b2b_time", 32'(Time), 10);
    chk("b2b_perr", 32'(ProtoErr), 0);
    for (int i = 7; i <= 15; i++) begin
      cyc(1, 0, 4'b0000, 0, 1);
      chk($sformatf("b2b_dstall%0d", i), 32'(Stall), 1);
    end
    cyc(1, 0, 4'b0000, 0, 1);
    chk("b2b_free", 32'(Stall), 0);

    // perf counter: div with D_MDUUse high throughout
    cyc(0, 0, 4'b0000, 0, 1);
    cyc(1, 1, 4'b0011, 0, 1);
    for (int i = 2; i <= 11; i++) cyc(1, 0, 4'b0000, 0, 1);
    chk("perf_stall", 32'(Stall), 0);
    chk("perf_cnt", PerfStallCnt, perf_exp);

    // reset mid-run: stall drops the cycle after reset
    cyc(1, 1, 4'b0001, 0, 1);
    cyc(1, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("midrst_hold", 32'(Stall), 1);
    cyc(1, 0, 4'b0000, 0, 1);
    chk("midrst_drop", 32'(Stall), 0);
    chk("midrst_perf", PerfStallCnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
